// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: state encoding, frame constants and default line/clock rates for the UART receiver.
package uart_byte_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS       = 8;
    localparam int DEF_BAUD        = 9600;
    localparam int DEF_CLOCK_FREQ  = 50_000_000;
    localparam int BAUD_CNT_W      = 30;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous RX pin into i_sysclk and flags synchronised falling edges.
module uart_rx_sync (
    input  logic i_sysclk,
    input  logic i_rst_n,
    input  logic i_uart_rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic prev;

    // All flops reset high so a released reset looks like an idle line.
    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= i_uart_rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 LSB-first UART receiver with mid-bit sampling; strobes each good byte or a framing error.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int BAUD       = DEF_BAUD,
    parameter int CLOCK_FREQ = DEF_CLOCK_FREQ
) (
    input  logic                 i_sysclk,
    input  logic                 i_rst_n,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int BAUD_COUNTER_MAX = CLOCK_FREQ / BAUD - 1;
    localparam int SAMPLE_POINT     = BAUD_COUNTER_MAX / 2;
    localparam logic [BAUD_CNT_W-1:0] CNT_MAX = BAUD_CNT_W'(BAUD_COUNTER_MAX);
    localparam logic [BAUD_CNT_W-1:0] CNT_MID = BAUD_CNT_W'(SAMPLE_POINT);
    localparam logic [2:0]            LAST_BIT = 3'(DATA_BITS - 1);

    logic                  rx_s;
    logic                  fall;
    state_t                state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  at_mid;
    logic                  at_end;

    uart_rx_sync u_sync (
        .i_sysclk  (i_sysclk),
        .i_rst_n   (i_rst_n),
        .i_uart_rx (i_uart_rx),
        .rx_s      (rx_s),
        .fall      (fall)
    );

    assign at_mid = baud_cnt == CNT_MID;
    assign at_end = baud_cnt == CNT_MAX;

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            baud_cnt    <= (state == IDLE || at_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: if (fall) state <= START;
                START: begin
                    if (at_mid && rx_s) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (at_mid) shift_reg[bit_cnt] <= rx_s;
                    if (at_end) begin
                        if (bit_cnt == LAST_BIT) state <= STOP;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a start bit right after the stop bit is still seen.
                    if (at_mid) begin
                        state       <= IDLE;
                        baud_cnt    <= '0;
                        o_rx_done   <= rx_s;
                        o_frame_err <= ~rx_s;
                        if (rx_s) o_data <= shift_reg;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
